// File: rtl/pci_reg_pkg.sv
// ============================================================================
// Module  : pci_reg_pkg
// Brief   : Ack codes, response status and FSM state types for pci_reg_initiator
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pci_reg_pkg;

    localparam logic [3:0] ACK_NONE  = 4'b0000;
    localparam logic [3:0] ACK_OK    = 4'b0001;
    localparam logic [3:0] ACK_RETRY = 4'b0010;
    localparam logic [3:0] ACK_ERROR = 4'b0100;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_ERROR   = 2'b01,
        RSP_RETRY   = 2'b10,
        RSP_TIMEOUT = 2'b11
    } rsp_status_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEL     = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pci_reg_initiator.sv
// ============================================================================
// Module  : pci_reg_initiator
// Brief   : Host-to-target register access initiator with retry and timeout
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_reg_initiator
    import pci_reg_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              reg_sel,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic [3:0]        pci_ack,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ack_spurious
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] C_TIMER_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] C_RETRY_LIMIT = RW'(MAX_RETRY);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [TW-1:0]       r_timer;
    logic [RW-1:0]       r_retry_cnt;
    logic                r_bo_cnt;
    rsp_status_t         r_status;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack_spurious;

    logic w_ack_ok;
    logic w_ack_retry;
    logic w_ack_err;
    logic w_retry_ok;
    logic w_expired;

    // Anything nonzero that is neither OK nor RETRY is treated as an error.
    assign w_ack_ok    = (pci_ack == ACK_OK);
    assign w_ack_retry = (pci_ack == ACK_RETRY);
    assign w_ack_err   = (pci_ack != ACK_NONE) && !w_ack_ok && !w_ack_retry;
    assign w_retry_ok  = (r_retry_cnt < C_RETRY_LIMIT);
    assign w_expired   = (r_timer == C_TIMER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) w_next = ST_SEL;
            end
            ST_SEL: begin
                if (w_ack_ok || w_ack_err) begin
                    w_next = ST_RESP;
                end else if (w_ack_retry) begin
                    w_next = w_retry_ok ? ST_BACKOFF : ST_RESP;
                end else if (w_expired) begin
                    w_next = ST_RESP;
                end
            end
            ST_BACKOFF: begin
                if (r_bo_cnt) w_next = ST_SEL;
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        reg_sel   = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_SEL:  reg_sel   = 1'b1;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
        reg_wr = reg_sel & r_write;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr         <= '0;
            r_wdata        <= '0;
            r_write        <= 1'b0;
            r_timer        <= '0;
            r_retry_cnt    <= '0;
            r_bo_cnt       <= 1'b0;
            r_status       <= RSP_OK;
            r_rdata        <= '0;
            r_ack_spurious <= 1'b0;
        end else begin
            r_ack_spurious <= (r_state != ST_SEL) && (pci_ack != ACK_NONE);
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_write     <= req_write;
                        r_timer     <= '0;
                        r_retry_cnt <= '0;
                        r_bo_cnt    <= 1'b0;
                        r_status    <= RSP_OK;
                        r_rdata     <= '0;
                    end
                end
                ST_SEL: begin
                    if (w_ack_ok) begin
                        r_status <= RSP_OK;
                        r_rdata  <= r_write ? '0 : reg_rdata;
                    end else if (w_ack_err) begin
                        r_status <= RSP_ERROR;
                        r_rdata  <= '0;
                    end else if (w_ack_retry) begin
                        if (w_retry_ok) begin
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                            r_bo_cnt    <= 1'b0;
                        end else begin
                            r_status <= RSP_RETRY;
                            r_rdata  <= '0;
                        end
                    end else if (w_expired) begin
                        r_status <= RSP_TIMEOUT;
                        r_rdata  <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    // Timer restarts so every SEL attempt gets the full window.
                    r_timer  <= '0;
                    r_bo_cnt <= ~r_bo_cnt;
                end
                default: ;
            endcase
        end
    end

    assign reg_addr     = r_addr;
    assign reg_wdata    = r_wdata;
    assign rsp_status   = r_status;
    assign rsp_rdata    = r_rdata;
    assign ack_spurious = r_ack_spurious;

endmodule

`default_nettype wire

// File: tb/tb_pci_reg_initiator.sv
// ============================================================================
// Module  : tb_pci_reg_initiator
// Brief   : Directed self-checking bench for pci_reg_initiator
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pci_reg_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        reg_sel;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [3:0]  pci_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        ack_spurious;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sel;
    int n_wr;
    int n_gap;

    always #5 clk = ~clk;

    pci_reg_initiator #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .TIMEOUT  (16),
        .MAX_RETRY(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .reg_sel     (reg_sel),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .pci_ack     (pci_ack),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_rdata   (rsp_rdata),
        .ack_spurious(ack_spurious)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive ack/rdata for the current cycle, tally activity, advance.
    task automatic step(input logic [3:0] ack, input logic [31:0] rd);
        pci_ack   = ack;
        reg_rdata = rd;
        if (reg_sel) n_sel++;
        if (reg_wr) n_wr++;
        if (!reg_sel && !rsp_valid && !req_ready) n_gap++;
        @(posedge clk);
        #1;
        pci_ack   = 4'b0;
        reg_rdata = 32'b0;
    endtask

    task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d);
        n_sel = 0; n_wr = 0; n_gap = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step(4'b0, 32'b0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; reg_rdata = '0; pci_ack = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_reg_sel", reg_sel, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_outputs", {reg_wr, reg_addr, reg_wdata, rsp_status, rsp_rdata, ack_spurious}, 0);
        rst = 1'b0;
        step(4'b0, 32'b0);

        // Write with OK three cycles after select
        send(1'b1, 8'h10, 32'h12345678);
        check("t1_sel_after_accept", reg_sel, 1);
        check("t1_addr", reg_addr, 8'h10);
        check("t1_wdata", reg_wdata, 32'h12345678);
        check("t1_req_ready_low", req_ready, 0);
        repeat (3) step(4'b0, 32'b0);
        step(4'b0001, 32'hDEADBEEF);
        check("t1_sel_cycles", n_sel, 4);
        check("t1_wr_cycles", n_wr, 4);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_sel_dropped", reg_sel, 0);
        check("t1_status", rsp_status, 2'b00);
        check("t1_rdata_zero", rsp_rdata, 0);
        finish_rsp();
        check("t1_req_ready_back", req_ready, 1);

        // Read acked in the first select cycle
        send(1'b0, 8'h04, 32'h0);
        check("t2_wr_low", reg_wr, 0);
        step(4'b0001, 32'hCAFEF00D);
        check("t2_rsp_latency", rsp_valid, 1);
        check("t2_status", rsp_status, 2'b00);
        check("t2_rdata", rsp_rdata, 32'hCAFEF00D);
        finish_rsp();

        // Two RETRYs then OK
        send(1'b0, 8'h20, 32'h0);
        step(4'b0010, 32'h0);
        step(4'b0, 32'h0);
        step(4'b0, 32'h0);
        check("t3_resel_after_backoff", reg_sel, 1);
        step(4'b0010, 32'h0);
        step(4'b0, 32'h0);
        step(4'b0, 32'h0);
        step(4'b0001, 32'h00C0FFEE);
        check("t3_gap_cycles", n_gap, 4);
        check("t3_sel_cycles", n_sel, 3);
        check("t3_status", rsp_status, 2'b00);
        check("t3_rdata", rsp_rdata, 32'h00C0FFEE);
        finish_rsp();

        // Four RETRYs exhaust MAX_RETRY=3
        send(1'b0, 8'h21, 32'h0);
        repeat (3) begin
            step(4'b0010, 32'h0);
            step(4'b0, 32'h0);
            step(4'b0, 32'h0);
        end
        check("t3b_still_selecting", reg_sel, 1);
        step(4'b0010, 32'h0);
        check("t3b_rsp_valid", rsp_valid, 1);
        check("t3b_status", rsp_status, 2'b10);
        check("t3b_rdata", rsp_rdata, 0);
        finish_rsp();

        // Silent target times out after 16 select cycles
        send(1'b1, 8'h30, 32'h55AA55AA);
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            step(4'b0, 32'h0);
            guard++;
        end
        check("t4_rsp_within_budget", rsp_valid, 1);
        check("t4_sel_cycles", n_sel, 16);
        check("t4_status", rsp_status, 2'b11);
        finish_rsp();

        // Ack on the last permitted cycle beats the timeout
        send(1'b0, 8'h31, 32'h0);
        repeat (15) step(4'b0, 32'h0);
        check("t4b_sel_alive", reg_sel, 1);
        step(4'b0001, 32'h13572468);
        check("t4b_status", rsp_status, 2'b00);
        check("t4b_rdata", rsp_rdata, 32'h13572468);
        finish_rsp();

        // Illegal ack and ERROR ack
        send(1'b0, 8'h40, 32'h0);
        step(4'b1000, 32'h11111111);
        check("t5_illegal_status", rsp_status, 2'b01);
        check("t5_illegal_rdata", rsp_rdata, 0);
        finish_rsp();
        send(1'b1, 8'h41, 32'h9);
        step(4'b0100, 32'h0);
        check("t5_error_status", rsp_status, 2'b01);
        finish_rsp();

        // Ack while idle
        check("t5_no_spurious", ack_spurious, 0);
        step(4'b0001, 32'h0);
        check("t5_spurious_pulse", ack_spurious, 1);
        check("t5_idle_kept", {req_ready, reg_sel, rsp_valid}, 3'b100);
        step(4'b0, 32'h0);
        check("t5_spurious_clears", ack_spurious, 0);

        // Asynchronous reset in the middle of an access
        send(1'b1, 8'h50, 32'h77);
        step(4'b0, 32'h0);
        check("t6_sel_before_rst", reg_sel, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_sel_drop", reg_sel, 0);
        check("t6_async_req_ready", req_ready, 1);
        check("t6_async_addr_clear", reg_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b0, 32'h0);

        // Response held while host stalls
        send(1'b0, 8'h60, 32'h0);
        step(4'b0001, 32'hA5A5A5A5);
        for (int i = 0; i < 5; i++) begin
            check("t6_hold_valid", rsp_valid, 1);
            check("t6_hold_fields", {rsp_status, rsp_rdata}, {2'b00, 32'hA5A5A5A5});
            check("t6_hold_req_ready", req_ready, 0);
            step(4'b0, 32'h0);
        end
        finish_rsp();
        check("t6_released", {req_ready, rsp_valid}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
